// File: rtl/delay_counter.sv
// One-shot delay timer: out rises after start has been high for N consecutive
// clock edges (N = CLOCK_SPEED_MHZ * US_DELAY, minimum 1) and stays high until start drops.
module delay_counter #(
   parameter int unsigned CLOCK_SPEED_MHZ = 12,
   parameter int unsigned US_DELAY        = 120000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic start,
   output logic out
);

   // The product is formed in 64 bits so long delays at fast clocks cannot overflow.
   localparam longint unsigned N_RAW = longint'(CLOCK_SPEED_MHZ) * longint'(US_DELAY);
   localparam longint unsigned N     = (N_RAW == 0) ? 64'd1 : N_RAW;
   localparam int              W     = (N <= 2) ? 1 : $clog2(N);
   localparam logic [W-1:0]    LAST  = W'(N - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNTING = 2'd1,
      DONE     = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] count_q, count_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // The count saturates at LAST; reaching it moves to DONE on that same edge,
   // which with N=1 lets IDLE jump straight to DONE.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (!start) begin
         state_d = IDLE;
         count_d = '0;
      end else begin
         case (state_q)
            IDLE, COUNTING: begin
               if (count_q == LAST) begin
                  state_d = DONE;
               end else begin
                  state_d = COUNTING;
                  count_d = count_q + W'(1);
               end
            end
            DONE:    state_d = DONE;
            default: begin
               state_d = IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   assign out = (state_q == DONE);

endmodule

// File: tb/tb_delay_counter.sv
// Self-checking bench for delay_counter at three delay lengths (N = 10, 1, 21),
// compared against a run-length model: out is expected once start has been high for N straight edges.
module tb_delay_counter;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [2:0] start_v = 3'b000;
   logic [2:0] out_v;

   int pass_cnt = 0;
   int total_cnt = 0;
   int run_len [3] = '{0, 0, 0};
   int n_of    [3] = '{10, 1, 21};

   always #5 CLK = ~CLK;

   delay_counter #(.CLOCK_SPEED_MHZ(1), .US_DELAY(10)) dut_a (
      .CLK(CLK), .RESET(RESET), .start(start_v[0]), .out(out_v[0]));
   delay_counter #(.CLOCK_SPEED_MHZ(1), .US_DELAY(0)) dut_b (
      .CLK(CLK), .RESET(RESET), .start(start_v[1]), .out(out_v[1]));
   delay_counter #(.CLOCK_SPEED_MHZ(3), .US_DELAY(7)) dut_c (
      .CLK(CLK), .RESET(RESET), .start(start_v[2]), .out(out_v[2]));

   function automatic logic expected_out(input int idx);
      return run_len[idx] >= n_of[idx];
   endfunction

   // Advance one edge, update the model from the inputs seen at that edge, then sample after it.
   task automatic tick();
      @(posedge CLK);
      for (int i = 0; i < 3; i++) begin
         if (RESET || !start_v[i]) run_len[i] = 0;
         else if (run_len[i] < 100000) run_len[i]++;
      end
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      start_v = 3'b111;
      for (int c = 0; c < 5; c++) begin
         tick();
         total_cnt++;
         if (out_v !== 3'b000) $display("FAIL reset_hold: out=%b expected 000 cycle %0d", out_v, c);
         else pass_cnt++;
      end
      RESET = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         total_cnt++;
         if (out_v[0] !== expected_out(0))
            $display("FAIL reset_release: out=%b expected %b edge %0d", out_v[0], expected_out(0), c);
         else pass_cnt++;
      end
      total_cnt++;
      if (out_v[0] !== 1'b1) $display("FAIL reset_release_final: out=%b expected 1", out_v[0]);
      else pass_cnt++;
   endtask

   task automatic test_nominal();
      start_v[0] = 1'b0;
      tick();
      start_v[0] = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         total_cnt++;
         if (out_v[0] !== expected_out(0))
            $display("FAIL nominal: out=%b expected %b edge %0d", out_v[0], expected_out(0), c);
         else pass_cnt++;
      end
   endtask

   task automatic test_abort();
      start_v[0] = 1'b0;
      tick();
      start_v[0] = 1'b1;
      for (int c = 0; c < 7; c++) tick();
      start_v[0] = 1'b0;
      tick();
      start_v[0] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         total_cnt++;
         if (out_v[0] !== ((c >= 10) ? 1'b1 : 1'b0))
            $display("FAIL abort: out=%b expected %b edge %0d", out_v[0], (c >= 10), c);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      start_v[0] = 1'b0;
      tick();
      total_cnt++;
      if (out_v[0] !== 1'b0) $display("FAIL rearm_drop: out=%b expected 0", out_v[0]);
      else pass_cnt++;
      start_v[0] = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         total_cnt++;
         if (out_v[0] !== expected_out(0))
            $display("FAIL rearm: out=%b expected %b edge %0d", out_v[0], expected_out(0), c);
         else pass_cnt++;
      end
   endtask

   task automatic test_minimum();
      start_v[1] = 1'b0;
      tick();
      start_v[1] = 1'b1;
      tick();
      total_cnt++;
      if (out_v[1] !== 1'b1) $display("FAIL minimum_rise: out=%b expected 1", out_v[1]);
      else pass_cnt++;
      start_v[1] = 1'b0;
      tick();
      total_cnt++;
      if (out_v[1] !== 1'b0) $display("FAIL minimum_fall: out=%b expected 0", out_v[1]);
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         RESET = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 29) == 0) start_v[i] = ~start_v[i];
         tick();
         for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (out_v[i] !== expected_out(i))
               $display("FAIL random_dut%0d: out=%b expected %b cycle %0d run=%0d",
                        i, out_v[i], expected_out(i), c, run_len[i]);
            else pass_cnt++;
         end
      end
      RESET = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_abort();
      test_back_to_back();
      test_minimum();
      test_random();
      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
